graph_fetch: RTL and testbench

GRAPH_FETCH -- requirements
Module: graph_fetch

---
 rtl/graph_fetch_if.sv | 27 ++
 rtl/graph_fetch.sv | 118 +++++++++++
 tb/tb_graph_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/graph_fetch_if.sv
// graph_fetch_if -- bundle of the fetch-side signals of graph_fetch.
//   Timing inputs : frame_start, line_end, line_active, graph_pixel[8:0]
//   VRAM port     : vram_addr[10:0], vram_rd (to VRAM), vram_data[7:0] (from VRAM)
//   Serializer    : pixel_code[7:0]
//   Status        : fetch_row[5:0]
// The slave modport is the fetch block; master is the timing generator / VRAM side.
interface graph_fetch_if;
    logic        frame_start;
    logic        line_end;
    logic        line_active;
    logic [8:0]  graph_pixel;
    logic [7:0]  vram_data;
    logic [10:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  pixel_code;
    logic [5:0]  fetch_row;

    modport slave (
        input  frame_start, line_end, line_active, graph_pixel, vram_data,
        output vram_addr, vram_rd, pixel_code, fetch_row
    );

    modport master (
        output frame_start, line_end, line_active, graph_pixel, vram_data,
        input  vram_addr, vram_rd, pixel_code, fetch_row
    );
endinterface

// File: rtl/graph_fetch.sv
// graph_fetch -- fetches 128x64 4-colour graphics bytes from VRAM.
//   pixel_clock : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : graph_fetch_if.slave (timing in, VRAM address/strobe out,
//                 VRAM data in, pixel_code and fetch_row out)
// Each 16-pixel group runs ADDR (pixel 1), READ (pixel 2), LATCH (pixel 3).
// Every graphics row is repeated on LINE_REPEAT display lines.
module graph_fetch #(
    parameter int LINE_REPEAT = 6,
    parameter int ROW_LAST    = 63
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    graph_fetch_if.slave  bus
);

    localparam logic [3:0] REP_MAX = 4'(LINE_REPEAT - 1);
    localparam logic [5:0] ROW_MAX = 6'(ROW_LAST);

    typedef enum logic [1:0] {PH_IDLE, PH_ADDR, PH_READ, PH_LATCH} phase_e;

    phase_e      phase_s;
    logic [10:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic [7:0]  code_q, code_d;
    logic [5:0]  row_q, row_d;
    logic [3:0]  rep_q, rep_d;
    // Remembers whether this group's ADDR phase was taken while active, so a
    // group whose address was never loaded cannot issue a read.
    logic        grp_ok_q, grp_ok_d;

    // Decode the fetch phase from the low pixel bits.
    always_comb begin
        case (bus.graph_pixel[3:0])
            4'b0001: phase_s = PH_ADDR;
            4'b0010: phase_s = PH_READ;
            4'b0011: phase_s = PH_LATCH;
            default: phase_s = PH_IDLE;
        endcase
    end

    // Next-state for address, read strobe, pixel latch and group qualifier.
    always_comb begin
        addr_d   = addr_q;
        rd_d     = 1'b0;
        code_d   = code_q;
        grp_ok_d = grp_ok_q;
        case (phase_s)
            PH_ADDR: begin
                grp_ok_d = bus.line_active;
                if (bus.line_active) begin
                    addr_d = {row_q, bus.graph_pixel[8:4]};
                end else begin
                    addr_d = addr_q;
                end
            end
            PH_READ: begin
                rd_d = bus.line_active & grp_ok_q;
            end
            PH_LATCH: begin
                if (bus.line_active) begin
                    code_d = bus.vram_data;
                end else begin
                    code_d = 8'h00;
                end
            end
            default: begin
                rd_d = 1'b0;
            end
        endcase
    end

    // Next-state for line repeat counter and graphics row.
    always_comb begin
        rep_d = rep_q;
        row_d = row_q;
        if (bus.frame_start) begin
            rep_d = 4'd0;
            row_d = 6'd0;
        end else if (bus.line_end && bus.line_active) begin
            if (rep_q < REP_MAX) begin
                rep_d = rep_q + 4'd1;
            end else begin
                rep_d = 4'd0;
                row_d = (row_q == ROW_MAX) ? 6'd0 : row_q + 6'd1;
            end
        end else begin
            rep_d = rep_q;
            row_d = row_q;
        end
    end

    // State registers; reset also drops the group qualifier so an interrupted
    // group is abandoned.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= 11'h000;
            rd_q     <= 1'b0;
            code_q   <= 8'h00;
            row_q    <= 6'd0;
            rep_q    <= 4'd0;
            grp_ok_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            code_q   <= code_d;
            row_q    <= row_d;
            rep_q    <= rep_d;
            grp_ok_q <= grp_ok_d;
        end
    end

    assign bus.vram_addr  = addr_q;
    assign bus.vram_rd    = rd_q;
    assign bus.pixel_code = code_q;
    assign bus.fetch_row  = row_q;

endmodule

// File: tb/tb_graph_fetch.sv
// Directed testbench for graph_fetch: two instances, LINE_REPEAT=6 and 1.
// VRAM model returns the low address byte as data.
module tb_graph_fetch;

    logic pixel_clock = 1'b0;
    logic reset_n     = 1'b1;

    always #5 pixel_clock = ~pixel_clock;

    graph_fetch_if bus0 ();
    graph_fetch_if bus1 ();

    assign bus0.vram_data = bus0.vram_addr[7:0];
    assign bus1.vram_data = bus1.vram_addr[7:0];

    graph_fetch #(.LINE_REPEAT(6), .ROW_LAST(63)) u_dut0 (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (bus0.slave)
    );

    graph_fetch #(.LINE_REPEAT(1), .ROW_LAST(63)) u_dut1 (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (bus1.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_count;
    int          rd_bad_phase;
    logic [10:0] rd_addrs[$];
    logic [7:0]  code_g5;
    logic [7:0]  code_p3;

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    // Apply one cycle of inputs to instance 0 and record any read strobe.
    task automatic step0(input logic fs, input logic le, input logic la, input logic [8:0] gp);
        bus0.frame_start = fs;
        bus0.line_end    = le;
        bus0.line_active = la;
        bus0.graph_pixel = gp;
        tick();
        if (bus0.vram_rd) begin
            rd_count++;
            rd_addrs.push_back(bus0.vram_addr);
            if (gp[3:0] != 4'b0010) rd_bad_phase++;
        end
        bus0.frame_start = 1'b0;
        bus0.line_end    = 1'b0;
    endtask

    task automatic step1(input logic fs, input logic le);
        bus1.frame_start = fs;
        bus1.line_end    = le;
        bus1.line_active = 1'b1;
        bus1.graph_pixel = 9'd0;
        tick();
        bus1.frame_start = 1'b0;
        bus1.line_end    = 1'b0;
    endtask

    task automatic clear_mon();
        rd_count     = 0;
        rd_bad_phase = 0;
        rd_addrs.delete();
    endtask

    // Full 512-pixel line ending with line_end on the last pixel.
    task automatic run_line(input logic la);
        clear_mon();
        for (int p = 0; p < 512; p++) begin
            step0(1'b0, (p == 511), la, 9'(p));
            if (p == 3)       code_p3 = bus0.pixel_code;
            if (p == 5*16+8)  code_g5 = bus0.pixel_code;
        end
    endtask

    // Short lines: a single active cycle carrying line_end, pixel in IDLE phase.
    task automatic quick_line(input int n);
        for (int i = 0; i < n; i++) step0(1'b0, 1'b1, 1'b1, 9'd0);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_checks++; if (bus0.vram_addr !== 11'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", bus0.vram_addr); end
        n_checks++; if (bus0.vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", bus0.vram_rd); end
        n_checks++; if (bus0.pixel_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h expected 00", bus0.pixel_code); end
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", bus0.fetch_row); end
        n_checks++; if (bus1.fetch_row !== 6'd0) begin n_fail++; $display("FAIL reset_row1: got %0d expected 0", bus1.fetch_row); end
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_sweep();
        step0(1'b1, 1'b0, 1'b1, 9'd0);
        run_line(1'b1);
        n_checks++; if (rd_count !== 32) begin n_fail++; $display("FAIL sweep_rd_count: got %0d expected 32", rd_count); end
        n_checks++; if (rd_bad_phase !== 0) begin n_fail++; $display("FAIL sweep_rd_phase: got %0d off-phase reads expected 0", rd_bad_phase); end
        begin
            int bad;
            bad = 0;
            foreach (rd_addrs[i]) if (rd_addrs[i] !== 11'(i)) bad++;
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep_addr_seq: got %0d wrong addresses expected 0", bad); end
        end
        n_checks++; if (code_g5 !== 8'h05) begin n_fail++; $display("FAIL sweep_code_g5: got %h expected 05", code_g5); end
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL sweep_row: got %0d expected 0", bus0.fetch_row); end
    endtask

    task automatic test_rows();
        step0(1'b1, 1'b0, 1'b1, 9'd0);
        quick_line(5);
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL rows_after5: got %0d expected 0", bus0.fetch_row); end
        quick_line(1);
        n_checks++; if (bus0.fetch_row !== 6'd1) begin n_fail++; $display("FAIL rows_after6: got %0d expected 1", bus0.fetch_row); end
        run_line(1'b1);
        n_checks++; if (rd_count !== 32) begin n_fail++; $display("FAIL rows_rd_count: got %0d expected 32", rd_count); end
        n_checks++; if (rd_addrs.size() == 32 && rd_addrs[0] !== 11'd32) begin n_fail++; $display("FAIL rows_first_addr: got %0d expected 32", rd_addrs[0]); end
        n_checks++; if (rd_addrs.size() == 32 && rd_addrs[31] !== 11'd63) begin n_fail++; $display("FAIL rows_last_addr: got %0d expected 63", rd_addrs[31]); end
        quick_line(376);
        n_checks++; if (bus0.fetch_row !== 6'd63) begin n_fail++; $display("FAIL rows_after383: got %0d expected 63", bus0.fetch_row); end
        quick_line(1);
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL rows_wrap384: got %0d expected 0", bus0.fetch_row); end
    endtask

    task automatic test_inactive();
        n_checks++; if (bus0.pixel_code !== 8'h3F) begin n_fail++; $display("FAIL inact_code_pre: got %h expected 3f", bus0.pixel_code); end
        quick_line(5);
        run_line(1'b0);
        n_checks++; if (rd_count !== 0) begin n_fail++; $display("FAIL inact_rd_count: got %0d expected 0", rd_count); end
        n_checks++; if (code_p3 !== 8'h00) begin n_fail++; $display("FAIL inact_code_blank: got %h expected 00", code_p3); end
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL inact_row_hold: got %0d expected 0", bus0.fetch_row); end
        quick_line(1);
        n_checks++; if (bus0.fetch_row !== 6'd1) begin n_fail++; $display("FAIL inact_rep_hold: got %0d expected 1", bus0.fetch_row); end
    endtask

    task automatic test_late_active();
        step0(1'b0, 1'b0, 1'b0, 9'h001);
        step0(1'b0, 1'b0, 1'b1, 9'h002);
        n_checks++; if (bus0.vram_rd !== 1'b0) begin n_fail++; $display("FAIL late_no_read: got %b expected 0", bus0.vram_rd); end
        n_checks++; if (bus0.vram_addr !== 11'd63) begin n_fail++; $display("FAIL late_addr_hold: got %0d expected 63", bus0.vram_addr); end
        step0(1'b0, 1'b0, 1'b1, 9'h003);
        n_checks++; if (bus0.pixel_code !== 8'h3F) begin n_fail++; $display("FAIL late_latch: got %h expected 3f", bus0.pixel_code); end
        step0(1'b0, 1'b0, 1'b1, 9'h011);
        n_checks++; if (bus0.vram_addr !== 11'd33) begin n_fail++; $display("FAIL late_next_addr: got %0d expected 33", bus0.vram_addr); end
        step0(1'b0, 1'b0, 1'b1, 9'h012);
        n_checks++; if (bus0.vram_rd !== 1'b1) begin n_fail++; $display("FAIL late_next_rd: got %b expected 1", bus0.vram_rd); end
        step0(1'b0, 1'b0, 1'b1, 9'h013);
        n_checks++; if (bus0.vram_rd !== 1'b0) begin n_fail++; $display("FAIL late_rd_one_cycle: got %b expected 0", bus0.vram_rd); end
        n_checks++; if (bus0.pixel_code !== 8'h21) begin n_fail++; $display("FAIL late_next_code: got %h expected 21", bus0.pixel_code); end
    endtask

    task automatic test_collision();
        step0(1'b1, 1'b0, 1'b1, 9'd0);
        quick_line(65);
        n_checks++; if (bus0.fetch_row !== 6'd10) begin n_fail++; $display("FAIL coll_pre_row: got %0d expected 10", bus0.fetch_row); end
        step0(1'b1, 1'b1, 1'b1, 9'd0);
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL coll_row: got %0d expected 0", bus0.fetch_row); end
        quick_line(5);
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL coll_rep_clear: got %0d expected 0", bus0.fetch_row); end
        quick_line(1);
        n_checks++; if (bus0.fetch_row !== 6'd1) begin n_fail++; $display("FAIL coll_rep_sixth: got %0d expected 1", bus0.fetch_row); end
    endtask

    task automatic test_reset_mid();
        step0(1'b1, 1'b0, 1'b1, 9'd0);
        for (int p = 1; p <= 'h22; p++) step0(1'b0, 1'b0, 1'b1, 9'(p));
        n_checks++; if (bus0.vram_rd !== 1'b1) begin n_fail++; $display("FAIL mid_rd_before: got %b expected 1", bus0.vram_rd); end
        n_checks++; if (bus0.vram_addr !== 11'd2) begin n_fail++; $display("FAIL mid_addr_before: got %0d expected 2", bus0.vram_addr); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus0.vram_rd !== 1'b0) begin n_fail++; $display("FAIL mid_rd_drop: got %b expected 0", bus0.vram_rd); end
        n_checks++; if (bus0.vram_addr !== 11'h000) begin n_fail++; $display("FAIL mid_addr_reset: got %0d expected 0", bus0.vram_addr); end
        n_checks++; if (bus0.pixel_code !== 8'h00) begin n_fail++; $display("FAIL mid_code_reset: got %h expected 00", bus0.pixel_code); end
        n_checks++; if (bus0.fetch_row !== 6'd0) begin n_fail++; $display("FAIL mid_row_reset: got %0d expected 0", bus0.fetch_row); end
        reset_n = 1'b1;
        clear_mon();
        for (int p = 'h23; p <= 'h33; p++) begin
            step0(1'b0, 1'b0, 1'b1, 9'(p));
            if (p == 'h31) begin
                n_checks++; if (bus0.vram_addr !== 11'd3) begin n_fail++; $display("FAIL mid_next_addr: got %0d expected 3", bus0.vram_addr); end
            end
            if (p == 'h32) begin
                n_checks++; if (bus0.vram_rd !== 1'b1) begin n_fail++; $display("FAIL mid_next_rd: got %b expected 1", bus0.vram_rd); end
            end
        end
        n_checks++; if (bus0.pixel_code !== 8'h03) begin n_fail++; $display("FAIL mid_next_code: got %h expected 03", bus0.pixel_code); end
        n_checks++; if (rd_count !== 1) begin n_fail++; $display("FAIL mid_rd_count: got %0d expected 1", rd_count); end
    endtask

    task automatic test_lr1();
        step1(1'b1, 1'b0);
        step1(1'b0, 1'b1);
        n_checks++; if (bus1.fetch_row !== 6'd1) begin n_fail++; $display("FAIL lr1_first: got %0d expected 1", bus1.fetch_row); end
        for (int i = 0; i < 62; i++) step1(1'b0, 1'b1);
        n_checks++; if (bus1.fetch_row !== 6'd63) begin n_fail++; $display("FAIL lr1_63: got %0d expected 63", bus1.fetch_row); end
        step1(1'b0, 1'b1);
        n_checks++; if (bus1.fetch_row !== 6'd0) begin n_fail++; $display("FAIL lr1_wrap: got %0d expected 0", bus1.fetch_row); end
    endtask

    initial begin
        bus0.frame_start = 1'b0; bus0.line_end = 1'b0; bus0.line_active = 1'b0; bus0.graph_pixel = 9'd0;
        bus1.frame_start = 1'b0; bus1.line_end = 1'b0; bus1.line_active = 1'b0; bus1.graph_pixel = 9'd0;
        clear_mon();
        code_g5 = 8'h00;
        code_p3 = 8'h00;
        test_reset();
        test_sweep();
        test_rows();
        test_inactive();
        test_late_active();
        test_collision();
        test_reset_mid();
        test_lr1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
